// File: rtl/key_decode_pkg.sv
// ============================================================================
// key_decode_pkg
// Shared types and helpers for the one-hot key decoder: debounce FSM state
// encoding, debounce counter sizing and the default kit clock frequency.
// Revision: 1.0
// ============================================================================
`default_nettype none

package key_decode_pkg;

   // Debounce FSM state encoding
   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_COUNT = 1'b1
   } deb_state_e;

   // Kit oscillator frequency; DEB_CYCLES/BLINK_DIV defaults assume it
   localparam int unsigned CLK_HZ_DEFAULT = 50_000_000;

   // Width of a counter that must hold 0 .. cycles-1 (at least one bit)
   function automatic int unsigned deb_cnt_width(input int unsigned cycles);
      if (cycles <= 2) begin
         return 1;
      end
      return $clog2(cycles);
   endfunction

endpackage : key_decode_pkg

`default_nettype wire

// File: rtl/key_debounce.sv
// ============================================================================
// key_debounce
// Two-flop synchroniser followed by a debounce FSM. A new input vector is
// accepted into the stable vector only after it has been held unchanged for
// DEB_CYCLES cycles; accept_o pulses for one cycle together with the update.
// Revision: 1.0
// ============================================================================
`default_nettype none

module key_debounce
   import key_decode_pkg::*;
#(
   parameter int unsigned WIDTH      = 3,
   parameter int unsigned DEB_CYCLES = 1000000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] raw_i,
   output logic [WIDTH-1:0] stable_o,
   output logic             accept_o
);

   localparam int unsigned      CNT_W    = deb_cnt_width(DEB_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

   logic [WIDTH-1:0] sync1_q;
   logic [WIDTH-1:0] sync2_q;
   logic [WIDTH-1:0] cand_q;     // candidate value currently being timed
   logic [WIDTH-1:0] stable_q;
   logic [CNT_W-1:0] cnt_q;
   logic             accept_q;
   deb_state_e       state_q;

   // Two-flop synchroniser; released keys read as 1
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= '1;
         sync2_q <= '1;
      end else begin
         sync1_q <= raw_i;
         sync2_q <= sync1_q;
      end
   end

   // Debounce FSM: time a candidate; restart whenever the synchronised value moves
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         cand_q   <= '1;
         stable_q <= '1;
         accept_q <= 1'b0;
      end else begin
         accept_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (sync2_q != stable_q) begin
                  // The sample that reveals the difference is the first stable one
                  state_q <= ST_COUNT;
                  cand_q  <= sync2_q;
                  cnt_q   <= CNT_W'(1);
               end else begin
                  cnt_q <= '0;
               end
            end
            ST_COUNT: begin
               if (sync2_q != cand_q) begin
                  cnt_q  <= '0;
                  cand_q <= sync2_q;
                  if (sync2_q == stable_q) begin
                     state_q <= ST_IDLE;
                  end
               end else if (cnt_q == CNT_LAST) begin
                  stable_q <= sync2_q;
                  accept_q <= 1'b1;
                  cnt_q    <= '0;
                  state_q  <= ST_IDLE;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            default: begin
               state_q <= ST_IDLE;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   assign stable_o = stable_q;
   assign accept_o = accept_q;

endmodule : key_debounce

`default_nettype wire

// File: rtl/key_onehot_decoder.sv
// ============================================================================
// key_onehot_decoder
// Debounced SEL_W-key to 2**SEL_W one-hot LED decoder with lamp-test key,
// change pulse and valid flag. Optional blinking of the selected LED is built
// in when KEY_ONEHOT_DECODER_BLINK_EN is defined.
// Revision: 1.0
// ============================================================================
`default_nettype none

module key_onehot_decoder
   import key_decode_pkg::*;
#(
   parameter int unsigned SEL_W      = 2,
   parameter int unsigned DEB_CYCLES = 1000000,
   parameter bit          ACT_LOW    = 1'b1,
   parameter int unsigned BLINK_DIV  = 12500000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [SEL_W-1:0]      key_sel,
   input  logic                  key_test,
   output logic [(2**SEL_W)-1:0] led,
   output logic [SEL_W-1:0]      idx,
   output logic                  changed,
   output logic                  valid
);

   localparam int unsigned      OUT_N   = 2**SEL_W;
   localparam logic [OUT_N-1:0] LED_OFF = {OUT_N{ACT_LOW}};

   logic [SEL_W:0]     stable_w;
   logic               accept_w;

   logic [SEL_W-1:0]   idx_d;
   logic               test_d;
   logic [OUT_N-1:0]   lit_d;      // active-high LED pattern
   logic               load_d;
   logic               chg_d;

   logic [OUT_N-1:0]   lit_q;
   logic [SEL_W-1:0]   idx_q;
   logic               test_q;
   logic               changed_q;
   logic               valid_q;
   logic [OUT_N-1:0]   lit_out_w;

   key_debounce #(
      .WIDTH      (SEL_W + 1),
      .DEB_CYCLES (DEB_CYCLES)
   ) u_debounce (
      .clk      (clk),
      .rst      (rst),
      .raw_i    ({key_test, key_sel}),
      .stable_o (stable_w),
      .accept_o (accept_w)
   );

   // Decode the stable (pressed = 0) vector into index, lamp test and LED pattern
   always_comb begin
      idx_d  = ~stable_w[SEL_W-1:0];
      test_d = ~stable_w[SEL_W];
      lit_d  = '0;
      if (test_d) begin
         lit_d = '1;
      end else begin
         lit_d[idx_d] = 1'b1;
      end
      // First post-reset cycle loads unconditionally; afterwards only on accept
      load_d = !valid_q || accept_w;
      chg_d  = valid_q && accept_w && ((idx_d != idx_q) || (test_d != test_q));
   end

   // Output registers; changed is raised on the same edge as the update
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lit_q     <= '0;
         idx_q     <= '0;
         test_q    <= 1'b0;
         changed_q <= 1'b0;
         valid_q   <= 1'b0;
      end else begin
         valid_q   <= 1'b1;
         changed_q <= chg_d;
         if (load_d) begin
            lit_q  <= lit_d;
            idx_q  <= idx_d;
            test_q <= test_d;
         end
      end
   end

`ifdef KEY_ONEHOT_DECODER_BLINK_EN
   localparam int unsigned      BLK_W    = (BLINK_DIV <= 2) ? 1 : $clog2(BLINK_DIV);
   localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);

   logic [BLK_W-1:0] blink_cnt_q;
   logic             phase_q;

   // Blink phase generator, restarted at phase 0 with every change pulse
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         blink_cnt_q <= '0;
         phase_q     <= 1'b0;
      end else if (chg_d) begin
         blink_cnt_q <= '0;
         phase_q     <= 1'b0;
      end else if (blink_cnt_q == BLK_LAST) begin
         blink_cnt_q <= '0;
         phase_q     <= ~phase_q;
      end else begin
         blink_cnt_q <= blink_cnt_q + BLK_W'(1);
      end
   end

   // Lamp test stays steady; the selected LED is lit only in phase 1
   assign lit_out_w = (test_q || phase_q) ? lit_q : '0;
`else
   assign lit_out_w = lit_q;
`endif

   assign led     = lit_out_w ^ LED_OFF;
   assign idx     = idx_q;
   assign changed = changed_q;
   assign valid   = valid_q;

endmodule : key_onehot_decoder

`default_nettype wire

// File: tb/tb_key_onehot_decoder.sv
// ============================================================================
// tb_key_onehot_decoder
// Directed testbench for key_onehot_decoder: reset state, debounce latency,
// glitch rejection, lamp test, simultaneous keys, reset mid-count and a
// second SEL_W=3 active-high instance.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_key_onehot_decoder;

   logic       clk;
   logic       rst;
   logic [1:0] key_sel;
   logic       key_test;
   logic [3:0] led;
   logic [1:0] idx;
   logic       changed;
   logic       valid;

   logic [2:0] key_sel2;
   logic       key_test2;
   logic [7:0] led2;
   logic [2:0] idx2;
   logic       changed2;
   logic       valid2;

   int checks = 0;
   int passes = 0;
   int fails  = 0;

   key_onehot_decoder #(
      .SEL_W      (2),
      .DEB_CYCLES (4),
      .ACT_LOW    (1'b1),
      .BLINK_DIV  (1000)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .key_sel  (key_sel),
      .key_test (key_test),
      .led      (led),
      .idx      (idx),
      .changed  (changed),
      .valid    (valid)
   );

   key_onehot_decoder #(
      .SEL_W      (3),
      .DEB_CYCLES (4),
      .ACT_LOW    (1'b0),
      .BLINK_DIV  (5)
   ) dut2 (
      .clk      (clk),
      .rst      (rst),
      .key_sel  (key_sel2),
      .key_test (key_test2),
      .led      (led2),
      .idx      (idx2),
      .changed  (changed2),
      .valid    (valid2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change and outputs are sampled on falling edges
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Expected LED drive of the ACT_LOW 2-bit instance
   function automatic logic [3:0] exp1(input logic [1:0] i, input logic test);
      logic [3:0] oh;
      if (test) return 4'b0000;
`ifdef KEY_ONEHOT_DECODER_BLINK_EN
      // Slow blink stays in phase 0 for the whole run: selected LED dark
      oh = 4'b0000;
      oh[i] = 1'b0;
      return ~oh;
`else
      oh = 4'b0000;
      oh[i] = 1'b1;
      return ~oh;
`endif
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; key_sel = 2'b11; key_test = 1'b1; key_sel2 = 3'b111; key_test2 = 1'b1;
      tick(3);
      check("rst_led",     led,      4'hF);
      check("rst_idx",     idx,      2'd0);
      check("rst_valid",   valid,    1'b0);
      check("rst_changed", changed,  1'b0);
      check("rst_led2",    led2,     8'h00);
      check("rst_valid2",  valid2,   1'b0);

      // First edge after release loads idx 0, no change pulse
      rst = 1'b0;
      tick(1);
      check("init_led",     led,     exp1(2'd0, 1'b0));
      check("init_idx",     idx,     2'd0);
      check("init_valid",   valid,   1'b1);
      check("init_changed", changed, 1'b0);
      tick(3);

      // 11 -> 10: idx 1 after exactly 7 edges
      key_sel = 2'b10;
      tick(6);
      check("lat6_idx",     idx,     2'd0);
      check("lat6_changed", changed, 1'b0);
      tick(1);
      check("sel1_idx",     idx,     2'd1);
      check("sel1_led",     led,     exp1(2'd1, 1'b0));
      check("sel1_changed", changed, 1'b1);
      tick(1);
      check("sel1_pulse_end", changed, 1'b0);

      // 3-cycle glitch is rejected
      key_sel = 2'b00;
      tick(3);
      key_sel = 2'b10;
      for (int i = 0; i < 8; i++) begin
         tick(1);
         check("glitch_changed", changed, 1'b0);
      end
      check("glitch_idx", idx, 2'd1);
      check("glitch_led", led, exp1(2'd1, 1'b0));

      // 4-cycle pulse equals DEB_CYCLES and is accepted, then undone
      key_sel = 2'b00;
      tick(4);
      key_sel = 2'b10;
      tick(3);
      check("pulse4_idx",     idx,     2'd3);
      check("pulse4_led",     led,     exp1(2'd3, 1'b0));
      check("pulse4_changed", changed, 1'b1);
      tick(4);
      check("pulse4_back_idx",     idx,     2'd1);
      check("pulse4_back_changed", changed, 1'b1);
      tick(2);

      // idx 2, then lamp test press and release
      key_sel = 2'b01;
      tick(7);
      check("sel2_idx",     idx,     2'd2);
      check("sel2_led",     led,     exp1(2'd2, 1'b0));
      check("sel2_changed", changed, 1'b1);
      key_test = 1'b0;
      tick(6);
      check("lt_pre_led", led, exp1(2'd2, 1'b0));
      tick(1);
      check("lt_led",     led,     4'b0000);
      check("lt_idx",     idx,     2'd2);
      check("lt_changed", changed, 1'b1);
      key_test = 1'b1;
      tick(7);
      check("lt_rel_led",     led,     exp1(2'd2, 1'b0));
      check("lt_rel_changed", changed, 1'b1);

      // Two keys one cycle apart: counter restarts, a single accept
      key_sel = 2'b00;
      tick(1);
      key_test = 1'b0;
      tick(7);
      check("multi_pre_changed", changed, 1'b0);
      check("multi_pre_idx",     idx,     2'd2);
      tick(1);
      check("multi_idx",     idx,     2'd3);
      check("multi_led",     led,     4'b0000);
      check("multi_changed", changed, 1'b1);
      for (int i = 0; i < 4; i++) begin
         tick(1);
         check("multi_single_pulse", changed, 1'b0);
      end

      // Simultaneous release of everything: one update back to idx 0
      key_sel = 2'b11; key_test = 1'b1;
      tick(7);
      check("rel_idx",     idx,     2'd0);
      check("rel_led",     led,     exp1(2'd0, 1'b0));
      check("rel_changed", changed, 1'b1);
      tick(2);

      // Reset two cycles into a count, then re-debounce of the held key
      key_sel = 2'b10;
      tick(4);
      rst = 1'b1;
      #1;
      check("mid_rst_led",     led,     4'hF);
      check("mid_rst_valid",   valid,   1'b0);
      check("mid_rst_idx",     idx,     2'd0);
      check("mid_rst_changed", changed, 1'b0);
      tick(2);
      rst = 1'b0;
      tick(1);
      check("post_rst_valid", valid, 1'b1);
      check("post_rst_idx",   idx,   2'd0);
      check("post_rst_led",   led,   exp1(2'd0, 1'b0));
      tick(5);
      check("post_rst_pre_idx", idx, 2'd0);
      tick(1);
      check("post_rst_idx1",     idx,     2'd1);
      check("post_rst_led1",     led,     exp1(2'd1, 1'b0));
      check("post_rst_changed1", changed, 1'b1);

      // Wide active-high instance: idx 5
      key_sel2 = 3'b010;
      tick(7);
      check("w_idx5",     idx2,     3'd5);
      check("w_changed5", changed2, 1'b1);
`ifdef KEY_ONEHOT_DECODER_BLINK_EN
      check("w_blink_p0a", led2, 8'h00);
      tick(4);
      check("w_blink_p0b", led2, 8'h00);
      tick(1);
      check("w_blink_p1a", led2, 8'h20);
      tick(4);
      check("w_blink_p1b", led2, 8'h20);
      tick(1);
      check("w_blink_p0c", led2, 8'h00);
`else
      check("w_led5", led2, 8'h20);
      tick(5);
      check("w_led5_steady",   led2,     8'h20);
      check("w_changed5_end",  changed2, 1'b0);
`endif

      // idx 3 on the wide instance
      key_sel2 = 3'b100;
      tick(7);
      check("w_idx3",     idx2,     3'd3);
      check("w_changed3", changed2, 1'b1);
`ifdef KEY_ONEHOT_DECODER_BLINK_EN
      check("w_blink_restart", led2, 8'h00);
      tick(5);
      check("w_blink_idx3_on", led2, 8'h08);
`else
      check("w_led3", led2, 8'h08);
`endif

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule : tb_key_onehot_decoder

`default_nettype wire
